// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator.
// A clock divider produces the pixel strobe, horizontal/vertical counters walk
// the full raster, and every output is registered on the pixel strobe so RGB,
// syncs, active and coordinates stay mutually aligned.
module vga_pattern_gen #(
    parameter int   CLK_DIV   = 4,
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter int   NUM_BARS  = 8,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   COLOR_W   = 4
) (
    input  logic                   clock,
    input  logic                   res,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   fg_color,
    output logic                   hsync,
    output logic                   vsync,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   active,
    output logic [9:0]             pixel_x,
    output logic [9:0]             pixel_y,
    output logic                   frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HBW      = H_VISIBLE / NUM_BARS;
    localparam int VBH      = V_VISIBLE / NUM_BARS;
    localparam int PW       = (HBW > 1) ? $clog2(HBW) : 1;
    localparam int LW       = (VBH > 1) ? $clog2(VBH) : 1;
    localparam int BW       = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int CW       = 3 * COLOR_W;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [PW-1:0] HB_LAST  = PW'(HBW - 1);
    localparam logic [LW-1:0] VB_LAST  = LW'(VBH - 1);

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_VBARS = 2'd1;
    localparam logic [1:0] MODE_HBARS = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    // Bar palette: bar 0 white down to bar 7 black, each channel all-ones or zero.
    function automatic logic [CW-1:0] bar_rgb(input logic [2:0] b);
        logic [2:0] c;
        c = 3'd7 - b;
        return {{COLOR_W{c[2]}}, {COLOR_W{c[1]}}, {COLOR_W{c[0]}}};
    endfunction

    logic [DW-1:0] div_r;
    logic [HW-1:0] h_cnt_r;
    logic [VW-1:0] v_cnt_r;
    logic [PW-1:0] hb_pix_r;
    logic [BW-1:0] hb_idx_r;
    logic [LW-1:0] vb_line_r;
    logic [BW-1:0] vb_idx_r;
    logic [1:0]    mode_r;
    logic [CW-1:0] fg_r;

    logic          pix_en_s;
    logic          line_end_s;
    logic          frame_end_s;
    logic          frame_origin_s;
    logic          visible_s;
    logic          hsync_on_s;
    logic          vsync_on_s;
    logic [1:0]    mode_eff_s;
    logic [CW-1:0] fg_eff_s;
    logic [CW-1:0] rgb_s;
    logic [9:0]    px_s;
    logic [9:0]    py_s;

    logic          hsync_r;
    logic          vsync_r;
    logic [CW-1:0] rgb_r;
    logic          active_r;
    logic [9:0]    pixel_x_r;
    logic [9:0]    pixel_y_r;
    logic          frame_start_r;

    // Raster position decode from the current counter values.
    always_comb begin
        pix_en_s       = (div_r == DIV_LAST);
        line_end_s     = (h_cnt_r == H_LAST);
        frame_end_s    = (v_cnt_r == V_LAST);
        frame_origin_s = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
        visible_s      = (int'(h_cnt_r) < H_VISIBLE) && (int'(v_cnt_r) < V_VISIBLE);
        hsync_on_s     = (int'(h_cnt_r) >= HS_START) && (int'(h_cnt_r) < HS_END);
        vsync_on_s     = (int'(v_cnt_r) >= VS_START) && (int'(v_cnt_r) < VS_END);
        px_s           = 10'(h_cnt_r);
        py_s           = 10'(v_cnt_r);
    end

    // At the frame origin the live inputs are used so the first pixel already
    // shows the newly sampled mode/colour; elsewhere the shadow copy applies.
    always_comb begin
        if (frame_origin_s) begin
            mode_eff_s = mode;
            fg_eff_s   = fg_color;
        end else begin
            mode_eff_s = mode_r;
            fg_eff_s   = fg_r;
        end
    end

    // Pattern colour for the current pixel, blanked outside the visible area.
    always_comb begin
        rgb_s = {CW{1'b0}};
        if (enable && visible_s) begin
            case (mode_eff_s)
                MODE_SOLID: rgb_s = fg_eff_s;
                MODE_VBARS: rgb_s = bar_rgb(3'(hb_idx_r));
                MODE_HBARS: rgb_s = bar_rgb(3'(vb_idx_r));
                MODE_CHECK: rgb_s = (px_s[5] ^ py_s[5]) ? fg_eff_s : {CW{1'b0}};
                default:    rgb_s = {CW{1'b0}};
            endcase
        end else begin
            rgb_s = {CW{1'b0}};
        end
    end

    // Pixel-rate divider; with CLK_DIV=1 it stays at zero and strobes every clock.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            div_r <= {DW{1'b0}};
        end else if (pix_en_s) begin
            div_r <= {DW{1'b0}};
        end else begin
            div_r <= div_r + DW'(1);
        end
    end

    // Horizontal and vertical raster counters, wrapping together at frame end.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
        end else if (pix_en_s) begin
            if (line_end_s) begin
                h_cnt_r <= {HW{1'b0}};
                if (frame_end_s) begin
                    v_cnt_r <= {VW{1'b0}};
                end else begin
                    v_cnt_r <= v_cnt_r + VW'(1);
                end
            end else begin
                h_cnt_r <= h_cnt_r + HW'(1);
            end
        end
    end

    // Vertical-bar index: counts pixels within a bar, restarts every line and
    // saturates on the last visible bar so it never outgrows its width.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            hb_pix_r <= {PW{1'b0}};
            hb_idx_r <= {BW{1'b0}};
        end else if (pix_en_s) begin
            if (line_end_s) begin
                hb_pix_r <= {PW{1'b0}};
                hb_idx_r <= {BW{1'b0}};
            end else if (int'(h_cnt_r) < H_VISIBLE - 1) begin
                if (hb_pix_r == HB_LAST) begin
                    hb_pix_r <= {PW{1'b0}};
                    hb_idx_r <= hb_idx_r + BW'(1);
                end else begin
                    hb_pix_r <= hb_pix_r + PW'(1);
                end
            end
        end
    end

    // Horizontal-bar index: counts lines within a bar, restarts every frame and
    // saturates on the last visible bar.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            vb_line_r <= {LW{1'b0}};
            vb_idx_r  <= {BW{1'b0}};
        end else if (pix_en_s && line_end_s) begin
            if (frame_end_s) begin
                vb_line_r <= {LW{1'b0}};
                vb_idx_r  <= {BW{1'b0}};
            end else if (int'(v_cnt_r) < V_VISIBLE - 1) begin
                if (vb_line_r == VB_LAST) begin
                    vb_line_r <= {LW{1'b0}};
                    vb_idx_r  <= vb_idx_r + BW'(1);
                end else begin
                    vb_line_r <= vb_line_r + LW'(1);
                end
            end
        end
    end

    // Shadow mode/colour, captured once per frame so a frame is never mixed.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            mode_r <= MODE_SOLID;
            fg_r   <= {CW{1'b0}};
        end else if (pix_en_s && frame_origin_s) begin
            mode_r <= mode;
            fg_r   <= fg_color;
        end
    end

    // Output stage: everything updates together on the pixel strobe.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            hsync_r   <= ~SYNC_POL;
            vsync_r   <= ~SYNC_POL;
            rgb_r     <= {CW{1'b0}};
            active_r  <= 1'b0;
            pixel_x_r <= 10'd0;
            pixel_y_r <= 10'd0;
        end else if (pix_en_s) begin
            hsync_r   <= hsync_on_s ? SYNC_POL : ~SYNC_POL;
            vsync_r   <= vsync_on_s ? SYNC_POL : ~SYNC_POL;
            rgb_r     <= rgb_s;
            active_r  <= visible_s;
            pixel_x_r <= px_s;
            pixel_y_r <= py_s;
        end
    end

    // Frame-start strobe: high only in the clock where outputs become (0,0).
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= pix_en_s && frame_origin_s;
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign red         = rgb_r[3*COLOR_W-1:2*COLOR_W];
    assign green       = rgb_r[2*COLOR_W-1:COLOR_W];
    assign blue        = rgb_r[COLOR_W-1:0];
    assign active      = active_r;
    assign pixel_x     = pixel_x_r;
    assign pixel_y     = pixel_y_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster (80x54 total, 64x48 visible)
// so several whole frames fit in a short run.
module tb_vga_pattern_gen;

    localparam int CLK_DIV = 2;
    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 48, VF = 2, VS = 2, VB = 2;
    localparam int NB = 8;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int LC = HT * CLK_DIV;
    localparam int FC = HT * VT * CLK_DIV;

    logic        clock = 1'b0;
    logic        res;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] fg_color;
    logic        hsync, vsync, active, frame_start;
    logic [3:0]  red, green, blue;
    logic [9:0]  pixel_x, pixel_y;

    vga_pattern_gen #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .NUM_BARS(NB), .SYNC_POL(1'b0), .COLOR_W(4)
    ) dut (
        .clock(clock), .res(res), .enable(enable), .mode(mode), .fg_color(fg_color),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .active(active), .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          stamp;
        logic        hs;
        logic        vs;
        logic        act;
        logic        fs;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [11:0] rgb;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    exp_t        rst_item;
    int          cyc = 0;
    int          frame_mode = 0;
    logic [11:0] frame_fg = 12'h000;
    int          passed = 0;
    int          total = 0;
    int          pushes = 0;
    int          pops = 0;
    int          fs_expected = 0;
    int          fs_seen = 0;
    int          t_rel = 0;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        total++;
        if (act_v === exp_v) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d, t=%0t)", name, act_v, exp_v, cyc, $time);
        end
    endtask

    function automatic logic [11:0] bar_color(input int b);
        int c;
        logic [3:0] r, g, bl;
        c  = 7 - (b % 8);
        r  = ((c / 4) % 2 == 1) ? 4'hF : 4'h0;
        g  = ((c / 2) % 2 == 1) ? 4'hF : 4'h0;
        bl = (c % 2 == 1) ? 4'hF : 4'h0;
        return {r, g, bl};
    endfunction

    function automatic logic [11:0] model_rgb(input int x, input int y, input int md,
                                              input logic [11:0] fg, input logic en);
        if (!en || x >= HV || y >= VV) return 12'h000;
        case (md)
            0:       return fg;
            1:       return bar_color(x / (HV / NB));
            2:       return bar_color(y / (VV / NB));
            default: return (((x / 32) % 2) != ((y / 32) % 2)) ? fg : 12'h000;
        endcase
    endfunction

    // Reference model: pixel n of the raster appears n+1 pixel periods after release.
    initial begin
        int   n, h, v;
        exp_t e;
        forever begin
            @(posedge clock);
            if (res) begin
                cyc = 0;
                q.delete();
            end else begin
                cyc = cyc + 1;
                if (cyc % CLK_DIV == 0) begin
                    n = cyc / CLK_DIV - 1;
                    h = n % HT;
                    v = (n / HT) % VT;
                    if (h == 0 && v == 0) begin
                        frame_mode = int'(mode);
                        frame_fg   = fg_color;
                        fs_expected++;
                    end
                    e.stamp = cyc;
                    e.hs    = !(h >= HV + HF && h < HV + HF + HS);
                    e.vs    = !(v >= VV + VF && v < VV + VF + VS);
                    e.act   = (h < HV) && (v < VV);
                    e.fs    = (h == 0) && (v == 0);
                    e.px    = 10'(h);
                    e.py    = 10'(v);
                    e.rgb   = model_rgb(h, v, frame_mode, frame_fg, enable);
                    q.push_back(e);
                    pushes++;
                end
            end
        end
    end

    // Monitor: compares outputs every negedge, popping a new pixel when one is due.
    initial begin
        logic fs_now;
        rst_item = '{stamp: 0, hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0,
                     px: 10'd0, py: 10'd0, rgb: 12'h000};
        cur = rst_item;
        forever begin
            @(negedge clock);
            fs_now = 1'b0;
            if (res) begin
                cur = rst_item;
            end else if (q.size() > 0 && q[0].stamp <= cyc) begin
                cur    = q.pop_front();
                fs_now = cur.fs;
                pops++;
            end
            check("hsync",       32'(hsync),       32'(cur.hs));
            check("vsync",       32'(vsync),       32'(cur.vs));
            check("active",      32'(active),      32'(cur.act));
            check("pixel_xy",    {12'd0, pixel_y, pixel_x}, {12'd0, cur.py, cur.px});
            check("rgb",         {20'd0, red, green, blue}, {20'd0, cur.rgb});
            check("frame_start", 32'(frame_start), 32'(fs_now));
            if (frame_start) fs_seen++;
        end
    end

    task automatic run_to(input int t);
        while (t_rel < t) begin
            @(posedge clock);
            #1;
            t_rel++;
        end
    endtask

    initial begin
        res      = 1'b1;
        enable   = 1'b1;
        mode     = 2'd0;
        fg_color = 12'h5A3;
        repeat (3) @(posedge clock);
        #1 res = 1'b0;
        t_rel = 0;

        // Frame 0 solid; a mode change at line 10 must wait for frame 1.
        run_to(10 * LC);
        mode     = 2'd2;
        fg_color = 12'($urandom);
        // Frame 1 horizontal bars; blank for a stretch mid-line.
        run_to(FC + 20 * LC + 34);
        enable = 1'b0;
        run_to(FC + 20 * LC + 74);
        enable = 1'b1;
        run_to(FC + 40 * LC);
        mode = 2'd1;
        // Frame 2 vertical bars, frame 3 checker in red.
        run_to(2 * FC + 40 * LC);
        mode     = 2'd3;
        fg_color = 12'hF00;
        // Random mode, colour and enable activity across frames 3-4.
        run_to(3 * FC + 50 * LC);
        while (t_rel < 5 * FC - 1000) begin
            run_to(t_rel + int'($urandom_range(100, 900)));
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                mode     = 2'($urandom);
                fg_color = 12'($urandom);
            end
        end
        enable = 1'b1;
        // Reset pulse in the middle of frame 5, then a full frame afterwards.
        run_to(5 * FC + 30 * LC + 7);
        res = 1'b1;
        repeat (5) @(posedge clock);
        #1 res = 1'b0;
        t_rel    = 0;
        mode     = 2'($urandom);
        fg_color = 12'($urandom);
        run_to(FC + 20 * LC);

        @(negedge clock);
        #1;
        check("frames_seen", 32'(fs_seen), 32'(fs_expected));
        check("pixels_drained", 32'(pops), 32'(pushes));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
